// File: rtl/fp16_aligner.sv
// ============================================================================
// fp16_aligner : two-stage FP16 magnitude unpacker / reference-exponent aligner
// Revision     : 1.0
// ============================================================================
`default_nettype none

module fp16_aligner #(
  parameter int DATA_WIDTH = 16,
  parameter int EXP_WIDTH  = 5,
  parameter int MANT_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-2:0]   in_data,
  input  logic [EXP_WIDTH-1:0]    in_ref_exp,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH:0]     out_data,
  output logic                    out_sticky,
  output logic                    out_err
);

  localparam int SIG_W  = MANT_WIDTH + 1;
  localparam int DIFF_W = EXP_WIDTH + 1;

  logic                  v1_q, v1_d;
  logic                  v2_q, v2_d;
  logic [EXP_WIDTH-1:0]  exp_q, exp_d;
  logic [MANT_WIDTH-1:0] frac_q, frac_d;
  logic [EXP_WIDTH-1:0]  ref_q, ref_d;
  logic                  zero_q, zero_d;
  logic [DIFF_W-1:0]     diff_q, diff_d;
  logic [DATA_WIDTH:0]   out_data_q, out_data_d;
  logic                  out_sticky_q, out_sticky_d;
  logic                  out_err_q, out_err_d;

  logic                  s2_load;
  logic                  s1_load;
  logic [SIG_W-1:0]      sig;
  logic [SIG_W-1:0]      sig_mask;

  assign s2_load   = !v2_q || out_ready;
  assign s1_load   = !v1_q || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = v2_q;
  assign out_data  = out_data_q;
  assign out_sticky = out_sticky_q;
  assign out_err   = out_err_q;

  always_comb begin
    v1_d   = v1_q;
    exp_d  = exp_q;
    frac_d = frac_q;
    ref_d  = ref_q;
    zero_d = zero_q;
    diff_d = diff_q;
    if (s1_load) begin
      v1_d = in_valid;
      if (in_valid) begin
        exp_d  = in_data[DATA_WIDTH-2:MANT_WIDTH];
        frac_d = in_data[MANT_WIDTH-1:0];
        ref_d  = in_ref_exp;
        zero_d = (in_data[DATA_WIDTH-2:MANT_WIDTH] == '0);
        // Sign bit of the widened difference flags ref < exp.
        diff_d = {1'b0, in_ref_exp} - {1'b0, in_data[DATA_WIDTH-2:MANT_WIDTH]};
      end
    end
  end

  always_comb begin
    sig          = {~zero_q, frac_q};
    sig_mask     = (SIG_W'(1) << diff_q) - SIG_W'(1);
    v2_d         = v2_q;
    out_data_d   = out_data_q;
    out_sticky_d = out_sticky_q;
    out_err_d    = out_err_q;
    if (s2_load) begin
      v2_d = v1_q;
      if (v1_q) begin
        // Subnormals are flushed, so a zero exponent yields an all-zero significand.
        if (zero_q) begin
          out_data_d   = {ref_q, {(SIG_W + 1){1'b0}}};
          out_sticky_d = 1'b0;
          out_err_d    = 1'b0;
        end else if (diff_q[DIFF_W-1]) begin
          out_data_d   = {exp_q, 1'b1, sig};
          out_sticky_d = 1'b0;
          out_err_d    = 1'b1;
        end else if (diff_q <= DIFF_W'(MANT_WIDTH)) begin
          out_data_d   = {ref_q, 1'b1, sig >> diff_q};
          out_sticky_d = |(sig & sig_mask);
          out_err_d    = 1'b0;
        end else begin
          out_data_d   = {ref_q, 1'b1, {SIG_W{1'b0}}};
          out_sticky_d = 1'b1;
          out_err_d    = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      exp_q        <= '0;
      frac_q       <= '0;
      ref_q        <= '0;
      zero_q       <= 1'b0;
      diff_q       <= '0;
      out_data_q   <= '0;
      out_sticky_q <= 1'b0;
      out_err_q    <= 1'b0;
    end else begin
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      exp_q        <= exp_d;
      frac_q       <= frac_d;
      ref_q        <= ref_d;
      zero_q       <= zero_d;
      diff_q       <= diff_d;
      out_data_q   <= out_data_d;
      out_sticky_q <= out_sticky_d;
      out_err_q    <= out_err_d;
    end
  end

endmodule

`default_nettype wire
